// File: rtl/alu_shift_seq_pkg.sv
// Shared definitions for the multi-cycle ALU shifter: op codes, FSM states and a
// width helper for the shift amount.
package alu_shift_seq_pkg;

  typedef enum logic [1:0] {
    OpSll = 2'b00,
    OpSrl = 2'b01,
    OpRor = 2'b10,
    OpSra = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } shift_state_e;

  // Bits of rs2 that form the shift amount for an xlen-bit operand.
  function automatic int unsigned shamt_width(input int unsigned xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/alu_shift_seq_step.sv
// Combinational single-step shifter: shifts acc by n (0..STEP) bits as a
// log2-stage mux barrel, one stage per bit of n.
module alu_shift_seq_step
  import alu_shift_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4,
  parameter int unsigned NW   = $clog2(STEP + 1)
) (
  input  logic [XLEN-1:0] acc,
  input  shift_op_e       op,
  input  logic [NW-1:0]   n,
  output logic [XLEN-1:0] res
);

  always_comb begin
    res = acc;
    for (int i = 0; i < int'(NW); i++) begin
      if (n[i]) begin
        unique case (op)
          OpSll: res = res << (1 << i);
          OpSrl: res = res >> (1 << i);
          OpSra: res = $unsigned($signed(res) >>> (1 << i));
          OpRor: res = (res >> (1 << i)) | (res << (XLEN - (1 << i)));
        endcase
      end
    end
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shifter (SLL/SRL/ROR/SRA) with valid/ready on both sides; shifts at
// most STEP bits per cycle.
module alu_shift_seq
  import alu_shift_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd
);

  localparam int unsigned RW = shamt_width(XLEN);
  localparam int unsigned NW = $clog2(STEP + 1);

  shift_state_e    state_q;
  shift_op_e       op_q;
  logic [XLEN-1:0] acc_q;
  logic [RW-1:0]   rem_q;
  logic [NW-1:0]   n;
  logic            last_step;
  logic [XLEN-1:0] step_res;
  logic [RW-1:0]   shamt;

  logic unused_rs2;
  assign unused_rs2 = ^rs2;

  assign shamt = rs2[RW-1:0];

  always_comb begin
    if (int'(rem_q) < int'(STEP)) begin
      n = NW'(rem_q);
    end else begin
      n = NW'(STEP);
    end
    last_step = int'(rem_q) <= int'(STEP);
  end

  alu_shift_seq_step #(
    .XLEN (XLEN),
    .STEP (STEP),
    .NW   (NW)
  ) u_step (
    .acc (acc_q),
    .op  (op_q),
    .n   (n),
    .res (step_res)
  );

  // rd is driven straight from the accumulator register, so it is frozen in StDone.
  assign rd = acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OpSll;
      acc_q     <= '0;
      rem_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (kill && state_q != StIdle) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A kill in idle does nothing except block the accept in that cycle.
          if (in_valid && !kill) begin
            acc_q    <= rs1;
            rem_q    <= shamt;
            op_q     <= shift_op_e'(op);
            in_ready <= 1'b0;
            if (shamt == '0) begin
              state_q   <= StDone;
              out_valid <= 1'b1;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          acc_q <= step_res;
          rem_q <= rem_q - RW'(n);
          if (last_step) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq: three instances (STEP=4, 1, 32) share one stimulus
// stream and are checked against a plain-arithmetic shift/latency model.
module tb_alu_shift_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic        out_ready;
  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic [31:0] rd_w        [3];

  int n_checks;
  int n_pass;

  alu_shift_seq #(.XLEN(32), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]), .op(op),
    .rs1(rs1), .rs2(rs2), .kill(kill), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .rd(rd_w[0])
  );
  alu_shift_seq #(.XLEN(32), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]), .op(op),
    .rs1(rs1), .rs2(rs2), .kill(kill), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .rd(rd_w[1])
  );
  alu_shift_seq #(.XLEN(32), .STEP(32)) u_s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]), .op(op),
    .rs1(rs1), .rs2(rs2), .kill(kill), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .rd(rd_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int step_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  // Reference result: ROR taken from the low half of the doubled word.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a,
                                            input int s);
    logic [63:0] dbl;
    dbl = {a, a} >> s;
    case (o)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b10:   return dbl[31:0];
      default: return $unsigned($signed(a) >>> s);
    endcase
  endfunction

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready_w[0] && in_ready_w[1] && in_ready_w[2]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_idle: in_ready=%b%b%b, required 111", in_ready_w[0], in_ready_w[1],
               in_ready_w[2]);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rd);
    int          s;
    int          exp_lat;
    int          lat   [3];
    logic [31:0] got   [3];
    bit          seen  [3];
    s = int'(b[4:0]);
    for (int i = 0; i < 3; i++) begin
      lat[i]  = -1;
      got[i]  = 'x;
      seen[i] = 1'b0;
    end
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && out_valid_w[i]) begin
          seen[i] = 1'b1;
          lat[i]  = k;
          got[i]  = rd_w[i];
        end
      end
      if (seen[0] && seen[1] && seen[2]) break;
    end
    for (int i = 0; i < 3; i++) begin
      exp_lat = 1 + (s + step_of(i) - 1) / step_of(i);
      n_checks++;
      if (lat[i] !== exp_lat) begin
        $display("FAIL latency step=%0d op=%0d rs2=%0d: got T+%0d, required T+%0d",
                 step_of(i), o, b, lat[i], exp_lat);
      end else n_pass++;
      n_checks++;
      if (got[i] !== exp_rd) begin
        $display("FAIL rd step=%0d op=%0d rs1=%h rs2=%0d: got %h, required %h",
                 step_of(i), o, a, b, got[i], exp_rd);
      end else n_pass++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({in_ready_w[i], out_valid_w[i], rd_w[i]} !== {1'b1, 1'b0, 32'h0}) begin
        $display("FAIL %s step=%0d: in_ready=%b out_valid=%b rd=%h, required 1 0 00000000",
                 tag, step_of(i), in_ready_w[i], out_valid_w[i], rd_w[i]);
      end else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0; kill = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op  [11] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b00,
                                2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] t_rs1 [11] = '{32'h2, 32'hFFFF_FFFF, 32'h8000_0000, 32'h4000_0000, 32'h1,
                                32'h1, 32'h1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                                32'hDEAD_BEEF};
    logic [31:0] t_rs2 [11] = '{32'd1, 32'd1, 32'd31, 32'd30, 32'd31, 32'd1, 32'd33,
                                32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] t_exp [11] = '{32'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000,
                                32'h8000_0000, 32'h2, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                                32'hDEAD_BEEF, 32'hDEAD_BEEF};
    for (int i = 0; i < 11; i++) run_op(t_op[i], t_rs1[i], t_rs2[i], t_exp[i]);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      run_op(o, a, b, ref_shift(o, a, int'(b[4:0])));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    logic [31:0] exp_rd;
    bit          got;
    a = $urandom;
    exp_rd = ref_shift(2'b00, a, 5);
    wait_idle();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; rs1 = a; rs2 = 32'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0; rs1 = $urandom;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid_w[0]) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got) $display("FAIL bp_valid: out_valid=0 after 20 cycles, required 1");
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid_w[0], in_ready_w[0], rd_w[0]} !== {1'b1, 1'b0, exp_rd}) begin
        $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b rd=%h, required 1 0 %h",
                 c, out_valid_w[0], in_ready_w[0], rd_w[0], exp_rd);
      end else n_pass++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid_w[0], in_ready_w[0]} !== 2'b01) begin
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid_w[0],
               in_ready_w[0]);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cnt [3];
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1; op = 2'b01; rs1 = $urandom; rs2 = 32'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 6) in_valid = 1'b0;
      for (int i = 0; i < 3; i++) if (out_valid_w[i]) cnt[i]++;
    end
    // shamt 0 gives one result every 2 cycles: 3 results in 6 edges.
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cnt[i] !== 3) begin
        $display("FAIL b2b step=%0d: got %0d results in 6 cycles, required 3", step_of(i),
                 cnt[i]);
      end else n_pass++;
    end
  endtask

  task automatic test_kill();
    int errs;
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1; op = 2'b11; rs1 = 32'h8000_0000 | $urandom; rs2 = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    kill = 1'b1; in_valid = 1'b1; rs2 = 32'd0;
    @(posedge clk);
    #1;
    kill = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({in_ready_w[i], out_valid_w[i]} !== 2'b10) begin
        $display("FAIL kill_idle step=%0d: in_ready=%b out_valid=%b, required 1 0",
                 step_of(i), in_ready_w[i], out_valid_w[i]);
      end else n_pass++;
    end
    errs = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid_w[0] || out_valid_w[1] || out_valid_w[2]) errs++;
    end
    n_checks++;
    if (errs !== 0) $display("FAIL kill_no_result: out_valid high %0d times, required 0", errs);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1; op = 2'b01; rs1 = $urandom | 32'h1; rs2 = 32'd31;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset_mid");
    a = $urandom;
    run_op(2'b10, a, 32'd13, ref_shift(2'b10, a, 13));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_kill();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
